// File: rtl/arith_pkg.sv
// Shared arithmetic-lab definitions: control states and default
// operand width, common to the multiplier and the divider.
package arith_pkg;

  localparam int ARITH_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

endpackage

// File: rtl/mul_seq_if.sv
// Operand/result bundle of the sequential multiplier.
// Master drives the load strobe and operands, slave returns the product.
interface mul_seq_if
  import arith_pkg::*;
#(
  parameter int W = ARITH_W
);

  logic             L;
  logic [W-1:0]     X;
  logic [W-1:0]     Y;
  logic [2*W-1:0]   P;
  logic             done;
  logic             busy;

  modport master (
    output L, X, Y,
    input  P, done, busy
  );

  modport slave (
    input  L, X, Y,
    output P, done, busy
  );

endinterface

// File: rtl/booth_step.sv
// One radix-2 Booth step: add/sub M per {Q[0],q_1}, then an
// arithmetic right shift of {A,Q,q_1}.
module booth_step #(
  parameter int W = 16
) (
  input  logic [W:0]   a_i,
  input  logic [W-1:0] q_i,
  input  logic         q1_i,
  input  logic [W:0]   m_i,
  output logic [W:0]   a_o,
  output logic [W-1:0] q_o,
  output logic         q1_o
);

  logic [W:0] sum;

  always_comb begin
    sum = a_i;
    unique case ({q_i[0], q1_i})
      2'b01:   sum = a_i + m_i;
      2'b10:   sum = a_i - m_i;
      default: sum = a_i;
    endcase
  end

  assign a_o  = {sum[W], sum[W:1]};
  assign q_o  = {sum[0], q_i[W-1:1]};
  assign q1_o = q_i[0];

endmodule

// File: rtl/mul_seq.sv
// Sequential signed Booth multiplier, one recoding step per clock,
// with a load-strobe handshake shared with the divider.
module mul_seq
  import arith_pkg::*;
#(
  parameter int W = ARITH_W
) (
  input  logic       clk,
  input  logic       rst,
  mul_seq_if.slave   bus
);

  localparam int CW = $clog2(W + 1);

  state_e           state_q, state_d;
  logic [W:0]       m_q, m_d;
  logic [W:0]       a_q, a_d;
  logic [W-1:0]     q_q, q_d;
  logic             q1_q, q1_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [2*W-1:0]   p_q, p_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;

  logic [W:0]       a_s;
  logic [W-1:0]     q_s;
  logic             q1_s;

  booth_step #(.W(W)) u_step (
    .a_i  (a_q),
    .q_i  (q_q),
    .q1_i (q1_q),
    .m_i  (m_q),
    .a_o  (a_s),
    .q_o  (q_s),
    .q1_o (q1_s)
  );

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    a_d     = a_q;
    q_d     = q_q;
    q1_d    = q1_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    done_d  = 1'b0;
    busy_d  = busy_q;
    unique case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (bus.L) begin
          m_d     = {bus.X[W-1], bus.X};
          a_d     = '0;
          q_d     = bus.Y;
          q1_d    = 1'b0;
          cnt_d   = CW'(W);
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d   = a_s;
        q_d   = q_s;
        q1_d  = q1_s;
        cnt_d = cnt_q - CW'(1);
        // Product comes from the freshly shifted value, not the registers
        if (cnt_q == CW'(1)) begin
          p_d     = {a_s[W-1:0], q_s};
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      m_q     <= '0;
      a_q     <= '0;
      q_q     <= '0;
      q1_q    <= 1'b0;
      cnt_q   <= '0;
      p_q     <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      a_q     <= a_d;
      q_q     <= q_d;
      q1_q    <= q1_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.P    = p_q;
  assign bus.done = done_q;
  assign bus.busy = busy_q;

endmodule
